// File: rtl/rs_pkg.sv
// rs_pkg: constants, state encoding and baud divisor shared by the
// RS-232 receiver and transmitter.
package rs_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int DATA_W     = 8;
  localparam int TCNT_W     = $clog2(OVERSAMPLE);
  localparam int BCNT_W     = $clog2(DATA_W);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_HIGH
  } rs_state_e;

  // Rounded clocks per oversample tick.
  function automatic int baud_div(input int clk_freq, input int baud);
    return (clk_freq + (OVERSAMPLE * baud) / 2) / (OVERSAMPLE * baud);
  endfunction

endpackage

// File: rtl/rs_baud_tick.sv
// rs_baud_tick: 16x oversample tick generator with synchronous restart.
// The tick is high on the last clock of each divider period.
module rs_baud_tick
  import rs_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic restart_i,
  output logic tick_o
);

  localparam int DIV = baud_div(CLK_FREQ, BAUD);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = tick_o ? '0 : cnt_q + 1'b1;
    if (restart_i) cnt_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/rs_rx.sv
// rs_rx: 16x-oversampled RS-232 receiver, 8 data bits, 1 stop bit.
// Define RS_RX_PARITY_EN to add an even-parity bit after bit 7.
module rs_rx
  import rs_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200
) (
  input  logic              CLK_50MHZ,
  input  logic              RST,
  input  logic              RS232_DCE_RXD,
  output logic [DATA_W-1:0] DATA,
  output logic              VALID,
  output logic              FRAME_ERR,
  output logic              PARITY_ERR,
  output logic              BUSY
);

  localparam logic [TCNT_W-1:0] MID  = TCNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TCNT_W-1:0] LAST = TCNT_W'(OVERSAMPLE - 1);
  localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(DATA_W - 1);

  logic rx_s1_q, rx_s2_q, rx_prev_q;
  logic fall, tick, restart;

  rs_state_e state_q, state_d;
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic valid_q, valid_d;
  logic ferr_q, ferr_d;
`ifdef RS_RX_PARITY_EN
  logic par_bad_q, par_bad_d;
  logic perr_q, perr_d;
`endif

  always_ff @(posedge CLK_50MHZ) begin
    if (RST) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= RS232_DCE_RXD;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  assign fall = rx_prev_q & ~rx_s2_q;

  rs_baud_tick #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD)
  ) u_tick (
    .clk_i    (CLK_50MHZ),
    .rst_i    (RST),
    .restart_i(restart),
    .tick_o   (tick)
  );

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    bcnt_d  = bcnt_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    restart = 1'b0;
`ifdef RS_RX_PARITY_EN
    par_bad_d = par_bad_q;
    perr_d    = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (fall) begin
          state_d = ST_START;
          restart = 1'b1;
          tcnt_d  = '0;
          bcnt_d  = '0;
        end
      end
      ST_START: begin
        if (tick) begin
          tcnt_d = tcnt_q + 1'b1;
          if (tcnt_q == MID) begin
            tcnt_d  = '0;
            state_d = rx_s2_q ? ST_IDLE : ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          tcnt_d = tcnt_q + 1'b1;
          if (tcnt_q == LAST) begin
            shreg_d = {rx_s2_q, shreg_q[DATA_W-1:1]};
            bcnt_d  = bcnt_q + 1'b1;
            if (bcnt_q == LAST_BIT) begin
`ifdef RS_RX_PARITY_EN
              state_d = ST_PARITY;
`else
              state_d = ST_STOP;
`endif
            end
          end
        end
      end
`ifdef RS_RX_PARITY_EN
      ST_PARITY: begin
        if (tick) begin
          tcnt_d = tcnt_q + 1'b1;
          if (tcnt_q == LAST) begin
            par_bad_d = ^{shreg_q, rx_s2_q};
            state_d   = ST_STOP;
          end
        end
      end
`endif
      ST_STOP: begin
        if (tick) begin
          tcnt_d = tcnt_q + 1'b1;
          if (tcnt_q == LAST) begin
            data_d = shreg_q;
            if (rx_s2_q) begin
              state_d = ST_IDLE;
`ifdef RS_RX_PARITY_EN
              valid_d = ~par_bad_q;
              perr_d  = par_bad_q;
`else
              valid_d = 1'b1;
`endif
            end else begin
              // A break must not be mistaken for a new start bit.
              ferr_d  = 1'b1;
              state_d = ST_WAIT_HIGH;
            end
          end
        end
      end
      ST_WAIT_HIGH: begin
        if (rx_s2_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK_50MHZ) begin
    if (RST) begin
      state_q <= ST_IDLE;
      tcnt_q  <= '0;
      bcnt_q  <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      bcnt_q  <= bcnt_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

`ifdef RS_RX_PARITY_EN
  always_ff @(posedge CLK_50MHZ) begin
    if (RST) begin
      par_bad_q <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      par_bad_q <= par_bad_d;
      perr_q    <= perr_d;
    end
  end

  assign PARITY_ERR = perr_q;
`else
  assign PARITY_ERR = 1'b0;
`endif

  assign DATA      = data_q;
  assign VALID     = valid_q;
  assign FRAME_ERR = ferr_q;
  assign BUSY      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rs_rx.sv
// tb_rs_rx: table, scenario and random checks of rs_rx against a
// frame-level model of the serial protocol.
module tb_rs_rx;

  localparam int CLK_FREQ = 50000000;
  localparam int BAUD     = 115200;
  localparam int DIVB = (CLK_FREQ + 8 * BAUD) / (16 * BAUD);
  localparam int BIT  = 16 * DIVB;
  localparam int SLOW = (BIT * 100) / 98;
`ifdef RS_RX_PARITY_EN
  localparam int EXP_LAT = (21 * BIT) / 2 + 3;
`else
  localparam int EXP_LAT = (19 * BIT) / 2 + 3;
`endif

  localparam int K_VALID = 1;
  localparam int K_FERR  = 2;
  localparam int K_PERR  = 3;
  localparam int K_BOTH  = 4;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       pinv;
  } frm_t;

  typedef struct {
    frm_t       f;
    int         kind;
    logic [7:0] ed;
    bit         lat;
  } vec_t;

  typedef struct {
    int         kind;
    logic [7:0] data;
    int         cyc;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd;
  logic [7:0] data;
  logic       valid, ferr, perr, busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int viol   = 0;
  ev_t ev_q[$];
  logic pv = 1'b0, pf = 1'b0, pp = 1'b0;

  always #10 clk = ~clk;

  rs_rx #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD)
  ) dut (
    .CLK_50MHZ    (clk),
    .RST          (rst),
    .RS232_DCE_RXD(rxd),
    .DATA         (data),
    .VALID        (valid),
    .FRAME_ERR    (ferr),
    .PARITY_ERR   (perr),
    .BUSY         (busy)
  );

  always @(posedge clk) cyc = cyc + 1;

  always @(posedge clk) begin
    ev_t e;
    #1;
    if (valid === 1'b1 && pv === 1'b1) viol++;
    if (ferr === 1'b1 && pf === 1'b1) viol++;
    if (perr === 1'b1 && pp === 1'b1) viol++;
    if (valid === 1'b1 && ferr === 1'b1) viol++;
    if (valid === 1'b1 || ferr === 1'b1 || perr === 1'b1) begin
      if (valid === 1'b1) e.kind = (ferr === 1'b1) ? K_BOTH : K_VALID;
      else if (ferr === 1'b1) e.kind = K_FERR;
      else e.kind = K_PERR;
      e.data = data;
      e.cyc  = cyc;
      ev_q.push_back(e);
    end
    pv = valid;
    pf = ferr;
    pp = perr;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic hold(input logic v, input int n);
    rxd = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input frm_t f, input int bclk,
                            output int t0);
    t0 = cyc;
    hold(1'b0, bclk);
    for (int i = 0; i < 8; i++) hold(f.data[i], bclk);
`ifdef RS_RX_PARITY_EN
    hold((^f.data) ^ f.pinv, bclk);
`endif
    hold(f.stop, bclk);
  endtask

  // Frame-level reference: stop bit beats parity, parity beats data.
  function automatic int model_kind(input frm_t f);
    if (!f.stop) return K_FERR;
`ifdef RS_RX_PARITY_EN
    if (f.pinv) return K_PERR;
`endif
    return K_VALID;
  endfunction

  function automatic vec_t mk(input logic [7:0] d, input logic s,
                              input logic pi, input int k,
                              input logic [7:0] ed, input bit lat);
    vec_t v;
    v.f.data = d;
    v.f.stop = s;
    v.f.pinv = pi;
    v.kind   = k;
    v.ed     = ed;
    v.lat    = lat;
    return v;
  endfunction

  task automatic check_frame(input string tag, input int kind,
                             input logic [7:0] ed, input bit lat,
                             input int t0);
    int d;
    chk({tag, "_count"}, ev_q.size(), 1);
    if (ev_q.size() > 0) begin
      chk({tag, "_kind"}, ev_q[0].kind, kind);
      chk({tag, "_data"}, ev_q[0].data, ed);
      if (lat) begin
        d = ev_q[0].cyc - t0;
        checks++;
        if (d < EXP_LAT - 2 || d > EXP_LAT + 2) begin
          errors++;
          $display("FAIL %s_latency: got %0d clocks, want %0d +/- 2",
                   tag, d, EXP_LAT);
        end
      end
    end
    chk({tag, "_port"}, data, ed);
    ev_q.delete();
  endtask

  initial begin
    vec_t tbl[$];
    frm_t f;
    int t0;
    int k;
    int bclk;
    logic [7:0] b2b[3];

    rst = 1'b1;
    rxd = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", data, 8'h00);
    chk("rst_valid", valid, 1'b0);
    chk("rst_ferr", ferr, 1'b0);
    chk("rst_perr", perr, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b0;
    hold(1'b1, 50);
    ev_q.delete();

    tbl.push_back(mk(8'h55, 1'b1, 1'b0, K_VALID, 8'h55, 1'b1));
    tbl.push_back(mk(8'h00, 1'b1, 1'b0, K_VALID, 8'h00, 1'b1));
    tbl.push_back(mk(8'hFF, 1'b1, 1'b0, K_VALID, 8'hFF, 1'b0));
    tbl.push_back(mk(8'h5A, 1'b0, 1'b0, K_FERR, 8'h5A, 1'b0));
`ifdef RS_RX_PARITY_EN
    tbl.push_back(mk(8'h07, 1'b1, 1'b1, K_PERR, 8'h07, 1'b0));
    tbl.push_back(mk(8'h07, 1'b1, 1'b0, K_VALID, 8'h07, 1'b0));
`endif
    foreach (tbl[i]) begin
      send_frame(tbl[i].f, BIT, t0);
      hold(1'b1, BIT);
      check_frame($sformatf("tbl%0d", i), tbl[i].kind, tbl[i].ed,
                  tbl[i].lat, t0);
    end

    // Glitch shorter than half a bit.
    hold(1'b0, 100);
    chk("glitch_busy_hi", busy, 1'b1);
    hold(1'b1, 120);
    chk("glitch_busy_lo", busy, 1'b0);
    hold(1'b1, BIT);
    chk("glitch_events", ev_q.size(), 0);

    // Stop bit low, then break held for two more bit times.
    f.data = 8'hA3;
    f.stop = 1'b0;
    f.pinv = 1'b0;
    send_frame(f, BIT, t0);
    hold(1'b0, 2 * BIT);
    chk("break_busy", busy, 1'b1);
    chk("break_events", ev_q.size(), 1);
    hold(1'b1, 10);
    chk("break_release", busy, 1'b0);
    hold(1'b1, BIT);
    check_frame("break", K_FERR, 8'hA3, 1'b0, t0);

    // Reset mid bit 4 of 0x3C; the receiver then locks onto the
    // falling edge at bit 6 and decodes 0xFE from the frame tail.
    f.data = 8'h3C;
    f.stop = 1'b1;
    fork
      send_frame(f, BIT, t0);
      begin
        repeat (5 * BIT + BIT / 2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
      end
    join
    chk("rstmid_events", ev_q.size(), 0);
    chk("rstmid_data", data, 8'h00);
    hold(1'b1, 8 * BIT);
    check_frame("rstmid_tail", K_VALID, 8'hFE, 1'b0, t0);
    f.data = 8'h81;
    send_frame(f, BIT, t0);
    hold(1'b1, BIT);
    check_frame("after_rst", K_VALID, 8'h81, 1'b1, t0);

    // Back-to-back at 2% slow baud.
    b2b[0] = 8'h00;
    b2b[1] = 8'hFF;
    b2b[2] = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      f.data = b2b[i];
      f.stop = 1'b1;
      f.pinv = 1'b0;
      send_frame(f, SLOW, t0);
    end
    hold(1'b1, BIT);
    chk("b2b_count", ev_q.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < ev_q.size()) begin
        chk($sformatf("b2b%0d_kind", i), ev_q[i].kind, K_VALID);
        chk($sformatf("b2b%0d_data", i), ev_q[i].data, b2b[i]);
      end
    end
    ev_q.delete();

    // Random frames at +/-2% baud.
    for (int i = 0; i < 5; i++) begin
      f.data = 8'($urandom_range(0, 255));
      f.stop = ($urandom_range(0, 3) != 0);
`ifdef RS_RX_PARITY_EN
      f.pinv = 1'($urandom_range(0, 1));
`else
      f.pinv = 1'b0;
`endif
      bclk = BIT - 8 + int'($urandom_range(0, 16));
      k = model_kind(f);
      send_frame(f, bclk, t0);
      hold(1'b1, BIT);
      check_frame($sformatf("rnd%0d", i), k, f.data, 1'b0, t0);
    end

    chk("pulse_rules", viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
